// File: rtl/serial_addsub_n_pkg.sv
// Shared helpers for the bit-serial add/subtract block.
package serial_addsub_n_pkg;

  // Bits needed to hold WIDTH-1; a single bit is still kept when WIDTH == 1.
  function automatic int cnt_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_n_fa_cell.sv
// Combinational 1-bit full adder used as the serial arithmetic element.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ cin;
  assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first,
// with start/busy/done handshake, carry-out and signed overflow.
module serial_addsub_n
  import serial_addsub_n_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res_r;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             co_bit;

  fa_cell u_fa (
    .a   (a_r[0]),
    .b   (b_r[0]),
    .cin (carry),
    .s   (s_bit),
    .co  (co_bit)
  );

  // New result bit enters at the MSB; after WIDTH shifts the LSB is in place.
  generate
    if (WIDTH == 1) begin : g_res_one
      assign res_next = s_bit;
    end else begin : g_res_wide
      assign res_next = {s_bit, res_r[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      res_r <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1, the +1 entering as the initial carry.
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          a_r   <= a_r >> 1;
          b_r   <= b_r >> 1;
          res_r <= res_next;
          carry <= co_bit;
          if (cnt == LAST) begin
            // carry still holds the carry into the MSB on this cycle.
            sum   <= res_next;
            cout  <= co_bit;
            ovf   <= carry ^ co_bit;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
